alu_seq: RTL and testbench

- Parametrised successor to the single-opcode ALU stage.
- Performs real arithmetic, logic, shift and multiply on WIDTH-bit operands, and keeps an x86-style flag register (ZF/SF/CF/OF).
- Ops come from the decoder as a compact 4-bit code with a start/busy/done handshake; multiply is iterative and multi-cycle.
- Sits between the register file / immediate path and the result bus, on the clock_5 execute phase.

---
 rtl/alu_seq.sv | 203 ++++++++++++++++++++
 tb/tb_alu_seq.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequenced ALU stage: single-cycle arithmetic/logic/shift ops plus an x86-style flag register.
// Define ALU_MUL_EN to build the iterative shift-add multiplier (op 0xB); otherwise 0xB is illegal.
module alu_seq #(
  parameter int unsigned WIDTH = 32,
  localparam int unsigned SHW = $clog2(WIDTH)
) (
  input  logic             clock_5,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] alu_result_bus,
  output logic [3:0]       flags,
  output logic             err
);

  localparam logic [3:0] OpMov = 4'h0;
  localparam logic [3:0] OpAdd = 4'h1;
  localparam logic [3:0] OpSub = 4'h2;
  localparam logic [3:0] OpAnd = 4'h3;
  localparam logic [3:0] OpOr  = 4'h4;
  localparam logic [3:0] OpXor = 4'h5;
  localparam logic [3:0] OpInc = 4'h6;
  localparam logic [3:0] OpDec = 4'h7;
  localparam logic [3:0] OpCmp = 4'h8;
  localparam logic [3:0] OpShl = 4'h9;
  localparam logic [3:0] OpShr = 4'hA;
`ifdef ALU_MUL_EN
  localparam logic [3:0] OpMul = 4'hB;
  localparam int unsigned CW = $clog2(WIDTH) + 1;
`endif

  localparam int unsigned Msb = WIDTH - 1;

`ifdef ALU_MUL_EN
  typedef enum logic {StIdle, StMulRun} state_e;
`else
  typedef enum logic {StIdle} state_e;
`endif

  state_e state_q;
  logic             busy_q, done_q, err_q;
  logic [WIDTH-1:0] result_q;
  logic [3:0]       flags_q;

  // Flag layout {OF, CF, SF, ZF}; this returns the {SF, ZF} pair for a result.
  function automatic logic [1:0] sz(input logic [WIDTH-1:0] r);
    return {r[WIDTH-1], r == '0};
  endfunction

  // Single-cycle datapath
  logic [WIDTH:0]   add_w, sub_w, shl_w, shr_w;
  logic [WIDTH-1:0] inc_r, dec_r, res_c;
  logic [3:0]       flg_c;
  logic [SHW-1:0]   sh;
  logic             add_of, sub_of, illegal;

  assign sh     = operand_b[SHW-1:0];
  assign add_w  = {1'b0, operand_a} + {1'b0, operand_b};
  assign sub_w  = {1'b0, operand_a} - {1'b0, operand_b};
  assign inc_r  = operand_a + WIDTH'(1);
  assign dec_r  = operand_a - WIDTH'(1);
  // Extra bit beyond the shifted word catches the last bit shifted out.
  assign shl_w  = {1'b0, operand_a} << sh;
  assign shr_w  = {operand_a, 1'b0} >> sh;
  assign add_of = (operand_a[Msb] == operand_b[Msb]) && (add_w[Msb] != operand_a[Msb]);
  assign sub_of = (operand_a[Msb] != operand_b[Msb]) && (sub_w[Msb] != operand_a[Msb]);

  always_comb begin
    res_c   = result_q;
    flg_c   = flags_q;
    illegal = 1'b0;
    case (op)
      OpMov: res_c = operand_b;
      OpAdd: begin
        res_c = add_w[WIDTH-1:0];
        flg_c = {add_of, add_w[WIDTH], sz(add_w[WIDTH-1:0])};
      end
      OpSub: begin
        res_c = sub_w[WIDTH-1:0];
        flg_c = {sub_of, sub_w[WIDTH], sz(sub_w[WIDTH-1:0])};
      end
      OpCmp: flg_c = {sub_of, sub_w[WIDTH], sz(sub_w[WIDTH-1:0])};
      OpAnd: begin
        res_c = operand_a & operand_b;
        flg_c = {2'b00, sz(operand_a & operand_b)};
      end
      OpOr: begin
        res_c = operand_a | operand_b;
        flg_c = {2'b00, sz(operand_a | operand_b)};
      end
      OpXor: begin
        res_c = operand_a ^ operand_b;
        flg_c = {2'b00, sz(operand_a ^ operand_b)};
      end
      OpInc: begin
        res_c = inc_r;
        flg_c = {inc_r[Msb] & ~operand_a[Msb], flags_q[2], sz(inc_r)};
      end
      OpDec: begin
        res_c = dec_r;
        flg_c = {~dec_r[Msb] & operand_a[Msb], flags_q[2], sz(dec_r)};
      end
      OpShl: begin
        if (sh != '0) begin
          res_c = shl_w[WIDTH-1:0];
          flg_c = {1'b0, shl_w[WIDTH], sz(shl_w[WIDTH-1:0])};
        end
      end
      OpShr: begin
        if (sh != '0) begin
          res_c = shr_w[WIDTH:1];
          flg_c = {1'b0, shr_w[0], sz(shr_w[WIDTH:1])};
        end
      end
`ifdef ALU_MUL_EN
      OpMul: begin
        // Handled by the sequencer.
      end
`endif
      default: illegal = 1'b1;
    endcase
  end

`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] acc_q, mcand_q, acc_nxt;
  logic [WIDTH-1:0]   mplier_q, mul_hi;
  logic [CW-1:0]      cnt_q;

  assign acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign mul_hi  = acc_nxt[2*WIDTH-1:WIDTH];
`endif

  always_ff @(posedge clock_5 or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
`ifdef ALU_MUL_EN
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
`ifdef ALU_MUL_EN
            if (op == OpMul) begin
              acc_q    <= '0;
              mcand_q  <= {{WIDTH{1'b0}}, operand_a};
              mplier_q <= operand_b;
              cnt_q    <= CW'(WIDTH);
              busy_q   <= 1'b1;
              state_q  <= StMulRun;
            end else begin
`else
            begin
`endif
              done_q   <= 1'b1;
              err_q    <= illegal;
              result_q <= res_c;
              flags_q  <= flg_c;
            end
          end
        end
`ifdef ALU_MUL_EN
        StMulRun: begin
          acc_q    <= acc_nxt;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q - CW'(1);
          // Last iteration writes back straight from the adder so done lands at N+WIDTH+1.
          if (cnt_q == CW'(1)) begin
            result_q <= acc_nxt[WIDTH-1:0];
            flags_q  <= {mul_hi != '0, mul_hi != '0, sz(acc_nxt[WIDTH-1:0])};
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= StIdle;
          end
        end
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;
  assign alu_result_bus = result_q;
  assign flags          = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=8; adapts MUL expectations to ALU_MUL_EN.
module tb_alu_seq;
  localparam int unsigned W = 8;

  logic         clock_5 = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   op = 4'h0;
  logic [W-1:0] operand_a = '0;
  logic [W-1:0] operand_b = '0;
  logic         busy, done, err;
  logic [W-1:0] alu_result_bus;
  logic [3:0]   flags;

  alu_seq #(.WIDTH(W)) dut (
    .clock_5       (clock_5),
    .reset_n       (reset_n),
    .start         (start),
    .op            (op),
    .operand_a     (operand_a),
    .operand_b     (operand_b),
    .busy          (busy),
    .done          (done),
    .alu_result_bus(alu_result_bus),
    .flags         (flags),
    .err           (err)
  );

  always #5 clock_5 = ~clock_5;

`ifdef ALU_MUL_EN
  localparam bit MulEn = 1'b1;
`else
  localparam bit MulEn = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   flg;
    logic         err;
    int           due;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int busy_end = 0;
  logic [W-1:0] m_res = '0;
  logic [3:0]   m_flg = '0;

  always @(posedge clock_5) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [3:0] mkf(input logic of, input logic cf, input logic [W-1:0] r);
    return {of, cf, r[W-1], r == '0};
  endfunction

  // Reference model, built on integer arithmetic.
  task automatic model_push(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    int ua, ub, sa, sbv, s, c;
    exp_t e;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sbv = int'($signed(b));
    c = ub % W;
    e.err = 1'b0;
    e.due = cyc + 1;
    case (o)
      4'h0: m_res = b;
      4'h1: begin
        s = sa + sbv;
        m_res = W'(ua + ub);
        m_flg = mkf(s > 127 || s < -128, (ua + ub) > 255, m_res);
      end
      4'h2, 4'h8: begin
        s = sa - sbv;
        if (o == 4'h2) m_res = W'(ua - ub);
        m_flg = mkf(s > 127 || s < -128, ua < ub, W'(ua - ub));
      end
      4'h3: begin m_res = a & b; m_flg = mkf(1'b0, 1'b0, m_res); end
      4'h4: begin m_res = a | b; m_flg = mkf(1'b0, 1'b0, m_res); end
      4'h5: begin m_res = a ^ b; m_flg = mkf(1'b0, 1'b0, m_res); end
      4'h6: begin m_res = W'(ua + 1); m_flg = mkf(sa == 127, m_flg[2], m_res); end
      4'h7: begin m_res = W'(ua - 1); m_flg = mkf(sa == -128, m_flg[2], m_res); end
      4'h9: if (c != 0) begin
        m_res = W'(ua << c);
        m_flg = mkf(1'b0, ((ua >> (W - c)) & 1) == 1, m_res);
      end
      4'hA: if (c != 0) begin
        m_res = W'(ua >> c);
        m_flg = mkf(1'b0, ((ua >> (c - 1)) & 1) == 1, m_res);
      end
      4'hB: begin
        if (MulEn) begin
          s = ua * ub;
          m_res = W'(s);
          m_flg = mkf(s > 255, s > 255, m_res);
          e.due = cyc + 1 + W;
          busy_end = e.due;
        end else begin
          e.err = 1'b1;
        end
      end
      default: e.err = 1'b1;
    endcase
    e.res = m_res;
    e.flg = m_flg;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1;
    op = o;
    operand_a = a;
    operand_b = b;
    if (cyc >= busy_end) model_push(o, a, b);
    @(posedge clock_5);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() > 0 && n < 40) begin
      @(posedge clock_5);
      #1 n++;
    end
    if (sb.size() > 0) begin
      check_eq("wait_timeout", 32'(sb.size()), 0);
      sb.delete();
    end
  endtask

  always @(negedge clock_5) begin
    if (reset_n) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        exp_t e;
        e = sb.pop_front();
        check_eq("done", 32'(done), 1);
        check_eq("result", 32'(alu_result_bus), 32'(e.res));
        check_eq("flags", 32'(flags), 32'(e.flg));
        check_eq("err", 32'(err), 32'(e.err));
      end else begin
        if (done) check_eq("spurious_done", 32'(done), 0);
        if (err) check_eq("spurious_err", 32'(err), 0);
        if (sb.size() > 0 && sb[0].due < cyc) begin
          check_eq("missed_done", 0, 1);
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nbusy;
    logic [3:0] ro;
    repeat (2) @(posedge clock_5);
    #1;
    check_eq("rst_result", 32'(alu_result_bus), 0);
    check_eq("rst_flags", 32'(flags), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_err", 32'(err), 0);
    reset_n = 1'b1;
    @(posedge clock_5);
    #1;

    issue(4'h1, 8'h7F, 8'h01);  // ADD overflow
    issue(4'h2, 8'h00, 8'h01);  // SUB borrow
    issue(4'h8, 8'h05, 8'h05);  // CMP equal, result held
    issue(4'h6, 8'hFF, 8'h00);  // INC wraps, CF kept
    issue(4'h9, 8'h81, 8'h01);  // SHL carries out
    issue(4'h9, 8'h55, 8'h08);  // count 0: flags kept
    issue(4'hA, 8'h81, 8'h03);
    issue(4'h7, 8'h80, 8'h00);  // DEC overflow
    issue(4'h0, 8'h3C, 8'h00);
    wait_idle();

    // MUL with an ignored start while busy
    issue(4'hB, 8'h10, 8'h20);
    nbusy = 0;
    for (int i = 0; i < 12; i++) begin
      if (busy) nbusy++;
      if (MulEn && i == 2) begin
        start = 1'b1;
        op = 4'h1;
        operand_a = 8'h01;
        operand_b = 8'h01;
      end else begin
        start = 1'b0;
      end
      @(posedge clock_5);
      #1;
    end
    start = 1'b0;
    check_eq("mul_busy_cycles", 32'(nbusy), MulEn ? 32'(W) : 0);
    wait_idle();

    issue(4'hB, 8'h03, 8'h07);
    wait_idle();

    // Reset in the middle of a multiply
    issue(4'hB, 8'h03, 8'h07);
    repeat (3) @(posedge clock_5);
    #1 reset_n = 1'b0;
    sb.delete();
    busy_end = 0;
    m_res = '0;
    m_flg = '0;
    #1;
    check_eq("midrst_busy", 32'(busy), 0);
    check_eq("midrst_result", 32'(alu_result_bus), 0);
    check_eq("midrst_flags", 32'(flags), 0);
    @(posedge clock_5);
    #1 reset_n = 1'b1;
    repeat (12) @(posedge clock_5);
    #1;

    // Illegal ops leave state alone, then back-to-back ADDs
    issue(4'h1, 8'hF0, 8'h20);
    issue(4'hD, 8'h12, 8'h34);
    issue(4'hF, 8'h00, 8'h00);
    issue(4'h1, 8'h01, 8'h02);
    issue(4'h1, 8'h80, 8'h80);
    issue(4'h1, 8'hFF, 8'h01);
    issue(4'h3, 8'hF0, 8'h0F);
    issue(4'h4, 8'h80, 8'h01);
    issue(4'h5, 8'hAA, 8'hAA);
    wait_idle();

    for (int i = 0; i < 40; i++) begin
      ro = 4'($urandom_range(0, 15));
      issue(ro, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      if (ro == 4'hB) wait_idle();
    end
    wait_idle();
    repeat (3) @(posedge clock_5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
